// File: rtl/serial_sub_pkg.sv
// serial_subtractor shared types: FSM state encoding and count sizing.
// Signed-overflow support is compiled in with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // One spare bit keeps the WIDTH-1 terminal compare from wrapping
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: di = ai - bi - br, bo = borrow out.
// Purely combinational so it can be unit-tested in isolation.
module serial_sub_cell
  import serial_sub_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic di,
  output logic bo
);

  logic w_x;

  assign w_x = ai ^ bi;
  assign di  = w_x ^ br;
  assign bo  = (~ai & bi) | (~w_x & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, one difference bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to enable the signed-overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             w_di;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_nxt;

`ifdef SERIAL_SUB_OVF_EN
  logic r_amsb;
  logic r_bmsb;
  logic r_ovf;
`endif

  serial_sub_cell u_cell (
    .ai (r_a_sr[0]),
    .bi (r_b_sr[0]),
    .br (r_br),
    .di (w_di),
    .bo (w_bo)
  );

  assign w_res_nxt = {w_di, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_res  <= w_res_nxt;
          r_br   <= w_bo;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_d     <= w_res_nxt;
            r_bout  <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            // Final cell output is the result MSB
            r_ovf   <= (r_amsb != r_bmsb) && (w_di != r_amsb);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4.
// Stimulus pushes expected results; a monitor pops them on done.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;
  logic       ovf;

  typedef struct {
    logic [3:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none pending");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d", int'(d), int'(e.d));
        chk("bout", int'(bout), int'(e.bout));
        chk("ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  // poke=1 issues a stray start with other operands mid-SHIFT
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        input logic ibin, input logic [3:0] ed,
                        input logic eb, input logic eo,
                        input bit poke);
    int cyc;
    exp_t e;
    @(negedge clk);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    e.d = ed; e.bout = eb; e.ovf = eo;
    q.push_back(e);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_shift", int'(busy), 1);
      end
      if (poke && cyc == 2) begin
        start = 1'b1;
        a     = 4'b0111;
        b     = 4'b1000;
        bin   = 1'b0;
      end
      if (poke && cyc == 3) start = 1'b0;
      if (done) break;
    end
    chk("latency", cyc, 5);
  endtask

  initial begin
    int cyc;
    int first;
    int second;
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1, 0);
    run_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 0);
`else
    run_op(4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0, 0);
    run_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b0, 0);
`endif
    run_op(4'b0001, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 0);
    run_op(4'b0001, 4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0, 1);
    run_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0);

    // Back-to-back: start held through the done cycle
    @(negedge clk);
    a = 4'b1111; b = 4'b0001; bin = 1'b0;
    start = 1'b1;
    e.d = 4'b1110; e.bout = 1'b0; e.ovf = 1'b0;
    q.push_back(e);
    q.push_back(e);
    cyc = 0; first = 0; second = 0;
    while (cyc < 30 && second == 0) begin
      @(negedge clk);
      cyc++;
      if (done && first == 0) first = cyc;
      else if (done) second = cyc;
      if (first != 0 && cyc == first + 1) begin
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
      end
    end
    chk("b2b_first", first, 5);
    chk("b2b_gap", second - first, 5);

    // Reset two cycles into SHIFT aborts the operation
    @(negedge clk);
    a = 4'b1100; b = 4'b0011; bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_d", int'(d), 0);
    chk("abort_bout", int'(bout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    run_op(4'b1100, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
